gf2_mult_ds: RTL and testbench

Parametrised digit-serial GF(2) polynomial multiplier. Computes the full unreduced carry-less product of two WIDTH-bit operands, processing DIGIT bits of b per cycle. It has valid/ready handshakes on input and output. It is the area-scalable successor to the fixed 20x20 single-stage multiplier and feeds the GF(2^163) reduction and Karatsuba combine logic unchanged.

---
 rtl/gf2_mult_ds.sv | 116 +++++++++++
 tb/tb_gf2_mult_ds.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf2_mult_ds.sv
// Digit-serial carry-less (GF(2)) multiplier: DIGIT bits of b per cycle,
// full 2*WIDTH-bit unreduced product, valid/ready on both sides.
module gf2_mult_ds #(
  parameter int WIDTH = 20,
  parameter int DIGIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] d
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int PW   = 2 * WIDTH;

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("gf2_mult_ds: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     d_q, d_d;
  logic              ov_q, ov_d;
  logic [PW-1:0]     pp;
  logic              last;

  // a_q is pre-shifted by the digit weight and b_q consumed LSB-first,
  // so the partial product needs no variable-distance shifter.
  always_comb begin
    pp = '0;
    for (int j = 0; j < DIGIT; j++) begin
      if (b_q[j]) pp = pp ^ (a_q << j);
    end
  end

  assign last = (cnt_q == CW'(NDIG - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    d_d     = d_q;
    ov_d    = ov_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = {{WIDTH{1'b0}}, a};
          b_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_q ^ pp;
        a_d   = a_q << DIGIT;
        b_d   = b_q >> DIGIT;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          d_d     = acc_q ^ pp;
          ov_d    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      d_q     <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      d_q     <= d_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = rst_n & (state_q == IDLE);
  assign out_valid = ov_q;
  assign d         = d_q;

endmodule

// File: tb/tb_gf2_mult_ds.sv
// Scoreboard bench for gf2_mult_ds: directed 20x4 instance plus
// randomized back-to-back sweeps over several WIDTH/DIGIT pairs.
module tb_gf2_mult_ds;

  typedef struct {
    logic [511:0] d;
    int           t;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   total = 0;
  int   bad   = 0;
  int   ndone = 0;
  logic srst_n;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    total++;
    bad++;
    $display("FAIL %s", nm);
  endtask

  // Textbook carry-less product: XOR of x shifted by every set bit of y.
  function automatic logic [511:0] clmul(input logic [511:0] x,
                                         input logic [511:0] y,
                                         input int w);
    logic [511:0] p;
    p = '0;
    for (int i = 0; i < w; i++) begin
      if (y[i]) p = p ^ (x << i);
    end
    return p;
  endfunction

  function automatic logic [511:0] ones(input int w);
    return (512'(1) << w) - 512'(1);
  endfunction

  function automatic logic [511:0] rnd(input int w);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r & ones(w);
  endfunction

  function automatic int sw(input int k);
    case (k)
      0: return 20;
      1: return 20;
      2: return 32;
      default: return 163;
    endcase
  endfunction

  function automatic int sd(input int k);
    case (k)
      0: return 1;
      1: return 20;
      2: return 8;
      default: return 1;
    endcase
  endfunction

  function automatic int sn(input int k);
    return (k == 3) ? 300 : 1000;
  endfunction

  // ---------------- directed instance (20,4) ----------------
  logic        rst0_n, iv0, ir0, ov0, or0;
  logic [19:0] a0, b0;
  logic [39:0] d0;
  exp_t        q0[$];
  int          rise0;
  logic        ovp0;

  gf2_mult_ds #(.WIDTH(20), .DIGIT(4)) u0 (
    .clk       (clk),
    .rst_n     (rst0_n),
    .in_valid  (iv0),
    .in_ready  (ir0),
    .a         (a0),
    .b         (b0),
    .out_valid (ov0),
    .out_ready (or0),
    .d         (d0)
  );

  always @(negedge clk) begin : mon0
    exp_t e;
    if (!rst0_n) begin
      ovp0 = 1'b0;
    end else begin
      if (ov0 && !ovp0) rise0 = cyc;
      if (ov0 && or0) begin
        if (q0.size() == 0) begin
          flag($sformatf("u0 spurious out_valid d=%0h", d0));
        end else begin
          e = q0.pop_front();
          chk("u0 d", 512'(d0), e.d);
          chk("u0 latency", 512'(rise0 - e.t), 512'(5));
          chk("u0 d msb", 512'(d0[39]), 512'(0));
        end
      end
      ovp0 = ov0;
    end
  end

  task automatic issue0(input logic [19:0] x, input logic [19:0] y,
                        input logic [39:0] e);
    int w;
    a0  = x;
    b0  = y;
    iv0 = 1'b1;
    w   = 0;
    while (!ir0 && w < 50) begin
      step();
      w++;
    end
    if (!ir0) begin
      flag("u0 accept timeout");
      iv0 = 1'b0;
      return;
    end
    q0.push_back('{512'(e), cyc + 1});
    step();
    iv0 = 1'b0;
    a0  = 20'($urandom);
    b0  = 20'($urandom);
  endtask

  task automatic wait_ov0();
    int w;
    w = 0;
    while (!ov0 && w < 20) begin
      chk("u0 busy in_ready", 512'(ir0), 512'(0));
      step();
      w++;
    end
    if (!ov0) flag("u0 out_valid timeout");
  endtask

  task automatic drain0();
    wait_ov0();
    step();
  endtask

  initial begin : dir0
    logic [39:0] e;
    rst0_n = 1'b0;
    iv0    = 1'b0;
    or0    = 1'b1;
    a0     = '0;
    b0     = '0;
    step();
    step();
    chk("reset in_ready", 512'(ir0), 512'(0));
    chk("reset out_valid", 512'(ov0), 512'(0));
    chk("reset d", 512'(d0), 512'(0));
    rst0_n = 1'b1;
    #1;
    chk("idle in_ready", 512'(ir0), 512'(1));

    issue0(20'h00003, 20'h00005, 40'h000000000F);
    drain0();
    issue0(20'hFFFFF, 20'hFFFFF, 40'h5555555555);
    drain0();
    issue0(20'h80000, 20'h80000, 40'h4000000000);
    drain0();
    issue0(20'h12345, 20'h00000, 40'h0);
    drain0();

    or0 = 1'b0;
    e   = 40'(clmul(512'(20'hABCDE), 512'(20'h13579), 20));
    issue0(20'hABCDE, 20'h13579, e);
    wait_ov0();
    for (int i = 0; i < 10; i++) begin
      a0  = 20'($urandom);
      b0  = 20'($urandom);
      iv0 = i[0];
      step();
      chk("bp out_valid", 512'(ov0), 512'(1));
      chk("bp d", 512'(d0), 512'(e));
      chk("bp in_ready", 512'(ir0), 512'(0));
    end
    iv0 = 1'b0;
    or0 = 1'b1;
    step();
    chk("bp release out_valid", 512'(ov0), 512'(0));
    chk("bp release in_ready", 512'(ir0), 512'(1));

    e = 40'(clmul(512'(20'h12345), 512'(20'h06789), 20));
    issue0(20'h12345, 20'h06789, e);
    step();
    rst0_n = 1'b0;
    step();
    chk("abort out_valid", 512'(ov0), 512'(0));
    chk("abort d", 512'(d0), 512'(0));
    chk("abort in_ready", 512'(ir0), 512'(0));
    q0.delete();
    rst0_n = 1'b1;
    #1;
    chk("abort idle", 512'(ir0), 512'(1));
    issue0(20'h00003, 20'h00005, 40'h000000000F);
    drain0();
    repeat (8) step();
    chk("u0 queue empty", 512'(q0.size()), 512'(0));
    ndone++;
  end

  // ---------------- randomized parameter sweep ----------------
  for (genvar k = 0; k < 4; k++) begin : g_sw
    localparam int W = sw(k);
    localparam int D = sd(k);
    localparam int N = W / D;
    localparam int NOPS = sn(k);

    logic           iv, ir, ov, ordy;
    logic [W-1:0]   av, bv;
    logic [2*W-1:0] dv;
    exp_t           q[$];
    int             rise;
    logic           ovp;

    gf2_mult_ds #(.WIDTH(W), .DIGIT(D)) u (
      .clk       (clk),
      .rst_n     (srst_n),
      .in_valid  (iv),
      .in_ready  (ir),
      .a         (av),
      .b         (bv),
      .out_valid (ov),
      .out_ready (ordy),
      .d         (dv)
    );

    always @(negedge clk) begin : mon
      exp_t e;
      if (!srst_n) begin
        ovp = 1'b0;
      end else begin
        if (ov && !ovp) rise = cyc;
        if (ov && ordy) begin
          if (q.size() == 0) begin
            flag($sformatf("w%0d_d%0d spurious out_valid", W, D));
          end else begin
            e = q.pop_front();
            chk($sformatf("w%0d_d%0d d", W, D), 512'(dv), e.d);
            chk($sformatf("w%0d_d%0d latency", W, D),
                512'(rise - e.t), 512'(N));
            chk($sformatf("w%0d_d%0d msb", W, D),
                512'(dv[2*W-1]), 512'(0));
          end
        end
        ovp = ov;
      end
    end

    initial begin : drv
      logic [511:0] x, y;
      int prev, w;
      iv   = 1'b0;
      ordy = 1'b1;
      av   = '0;
      bv   = '0;
      prev = -1;
      step();
      while (!srst_n) step();
      for (int n = 0; n < NOPS; n++) begin
        x = rnd(W);
        y = rnd(W);
        if (n % 17 == 0) x = ones(W);
        if (n % 13 == 5) y = '0;
        av = x[W-1:0];
        bv = y[W-1:0];
        iv = 1'b1;
        w  = 0;
        while (!ir && w < N + 10) begin
          step();
          w++;
        end
        if (!ir) begin
          flag($sformatf("w%0d_d%0d accept timeout", W, D));
          break;
        end
        if (prev >= 0)
          chk($sformatf("w%0d_d%0d period", W, D),
              512'(cyc + 1 - prev), 512'(N + 2));
        prev = cyc + 1;
        q.push_back('{clmul(x, y, W), cyc + 1});
        step();
      end
      iv = 1'b0;
      w  = 0;
      while (q.size() != 0 && w < N + 10) begin
        step();
        w++;
      end
      chk($sformatf("w%0d_d%0d queue empty", W, D),
          512'(q.size()), 512'(0));
      ndone++;
    end
  end

  initial begin : main
    int w;
    srst_n = 1'b0;
    repeat (3) step();
    srst_n = 1'b1;
    w = 0;
    while (ndone < 5 && w < 90000) begin
      step();
      w++;
    end
    if (ndone < 5) flag("global timeout");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
